// File: rtl/riscv_pipe_pkg.sv
// +----------------------------------------------------------------------------+
// | riscv_pipe_pkg : shared widths, reset PC and instruction constants          |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

package riscv_pipe_pkg;

  localparam int          XLEN_DEFAULT     = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] INSTR_NOP        = 32'h0000_0013;
  localparam int          INSTR_BYTES      = 4;

  // Width of an occupancy counter that must represent 0..depth inclusive.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ifq_fifo.sv
// +----------------------------------------------------------------------------+
// | ifq_fifo : synchronous FIFO with flush; push and pop may coincide at full  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module ifq_fifo
  import riscv_pipe_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush_i,
  input  logic                          push_i,
  input  logic [WIDTH-1:0]              data_i,
  input  logic                          pop_i,
  output logic [WIDTH-1:0]              data_o,
  output logic [cnt_width(DEPTH)-1:0]   count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = cnt_width(DEPTH);
  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push;
  logic             do_pop;

  always_comb begin
    do_pop   = pop_i && !flush_i && (count_q != '0);
    // A pop in the same cycle frees the slot being written, so full is no obstacle then.
    do_push  = push_i && !flush_i && ((count_q != FULL_C) || do_pop);
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

`default_nettype wire

// File: rtl/if_prefetch_queue.sv
// +----------------------------------------------------------------------------+
// | if_prefetch_queue : PC generator, credit-limited imem port, prefetch queue |
// | Optional IFQ_PERF_EN adds perf_stall_cnt (decode starved by fetch).        |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module if_prefetch_queue
  import riscv_pipe_pkg::*;
#(
  parameter int              XLEN     = XLEN_DEFAULT,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [XLEN-1:0] id_pc,
  output logic [XLEN-1:0] id_instr
`ifdef IFQ_PERF_EN
  ,
  output logic [31:0]     perf_stall_cnt
`endif
);

  localparam int CW = cnt_width(DEPTH);
  localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

  logic [XLEN-1:0]   fetch_pc_q, fetch_pc_d;
  logic [CW-1:0]     discard_q, discard_d;
  logic [CW-1:0]     iq_count;
  logic [CW-1:0]     tag_count;
  logic [XLEN-1:0]   tag_pc;
  logic [2*XLEN-1:0] iq_head;
  logic [CW:0]       outstanding;
  logic [CW:0]       inflight_total;
  logic              req_fire;
  logic              enq;
  logic              deq;

  // Every in-flight request either still owns a PC tag or is marked for discard,
  // so the outstanding count is the sum of the two.
  always_comb begin
    outstanding    = {1'b0, tag_count} + {1'b0, discard_q};
    inflight_total = {1'b0, iq_count} + outstanding;
    imem_req_valid = !redirect_valid && (inflight_total < DEPTH_C);
    imem_req_addr  = fetch_pc_q;
    req_fire       = imem_req_valid && imem_req_ready;
    enq            = imem_rsp_valid && (discard_q == '0) && !redirect_valid;
    id_valid       = (iq_count != '0);
    deq            = id_valid && id_ready && !redirect_valid;
    id_pc          = id_valid ? iq_head[2*XLEN-1:XLEN] : '0;
    id_instr       = id_valid ? iq_head[XLEN-1:0]      : '0;
  end

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    discard_d  = discard_q;
    if (redirect_valid) begin
      fetch_pc_d = redirect_pc;
      // Everything still in flight after this cycle's response is stale.
      discard_d  = CW'(outstanding - {{CW{1'b0}}, imem_rsp_valid});
    end else begin
      if (req_fire) fetch_pc_d = fetch_pc_q + XLEN'(INSTR_BYTES);
      if (imem_rsp_valid && (discard_q != '0)) discard_d = discard_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      fetch_pc_q <= RESET_PC;
      discard_q  <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      discard_q  <= discard_d;
    end
  end

  ifq_fifo #(
    .WIDTH (XLEN),
    .DEPTH (DEPTH)
  ) u_tag_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush_i (redirect_valid),
    .push_i  (req_fire),
    .data_i  (fetch_pc_q),
    .pop_i   (enq),
    .data_o  (tag_pc),
    .count_o (tag_count)
  );

  ifq_fifo #(
    .WIDTH (2*XLEN),
    .DEPTH (DEPTH)
  ) u_instr_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush_i (redirect_valid),
    .push_i  (enq),
    .data_i  ({tag_pc, imem_rsp_data}),
    .pop_i   (deq),
    .data_o  (iq_head),
    .count_o (iq_count)
  );

`ifdef IFQ_PERF_EN
  logic [31:0] perf_q, perf_d;

  always_comb begin
    perf_d = perf_q;
    if (id_ready && !id_valid && !redirect_valid && (perf_q != 32'hFFFF_FFFF))
      perf_d = perf_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst) perf_q <= '0;
    else      perf_q <= perf_d;
  end

  assign perf_stall_cnt = perf_q;
`endif

endmodule

`default_nettype wire
